alu32_op_sequencer: RTL

//  Upstream issue stage for alu32 (registered 32-bit logic ALU, 1-cycle latency).
//  - Accepts tagged ALU ops over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
//  - Drives alu32's a/b/sel from registers and returns the ALU result with its tag over a

---
 rtl/alu32_pkg.sv | 33 +++
 rtl/alu32_op_sequencer_if.sv | 31 +++
 rtl/alu32.sv | 25 ++
 rtl/alu32_op_fifo.sv | 71 +++++++
 rtl/alu32_op_sequencer.sv | 128 ++++++++++++
 5 files changed

// File: rtl/alu32_pkg.sv
// alu32_pkg
//   Shared definitions for the alu32 issue stage:
//   - alu32 opcode encodings and the legality check for an opcode
//   - default tag width and the packed op width {a, b, sel, tag}
//   - sequencer FSM state encodings
package alu32_pkg;

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_NOTA = 4'b0010;
  localparam logic [3:0] SEL_XOR  = 4'b0011;

  localparam int DEF_TAG_W = 4;
  // Packed op: a(32) + b(32) + sel(4) + tag(TAG_W)
  localparam int OP_W = 68 + DEF_TAG_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Packed op width for an arbitrary tag width.
  function automatic int op_width(input int tag_w);
    return 68 + tag_w;
  endfunction

  // alu32 implements only opcodes 0000..0011.
  function automatic logic sel_legal(input logic [3:0] sel);
    return (sel[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/alu32_op_sequencer_if.sv
// alu32_op_sequencer_if
//   Op-issue and result channels of the alu32 sequencer.
//   in_*  : valid/ready op channel (producer -> sequencer)
//   res_* : valid/ready result channel (sequencer -> consumer)
//   master modport: the producer/consumer side; slave modport: the sequencer.
interface alu32_op_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [3:0]       in_sel;
  logic [TAG_W-1:0] in_tag;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  modport master (
    output in_valid, in_a, in_b, in_sel, in_tag, res_ready,
    input  in_ready, res_valid, res_data, res_tag, res_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_tag, res_ready,
    output in_ready, res_valid, res_data, res_tag, res_err
  );
endinterface

// File: rtl/alu32.sv
// alu32
//   Registered 32-bit logic ALU, one cycle latency, no reset.
//   Ports: clk; a, b operands; sel opcode; out registered result.
//   Opcodes outside 0000..0011 leave out unchanged.
module alu32
  import alu32_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  sel,
  output logic [31:0] out
);

  always_ff @(posedge clk) begin
    case (sel)
      SEL_AND:  out <= a & b;
      SEL_OR:   out <= a | b;
      SEL_NOTA: out <= ~a;
      SEL_XOR:  out <= a ^ b;
      default:  out <= out;
    endcase
  end

endmodule

// File: rtl/alu32_op_fifo.sv
// alu32_op_fifo
//   Synchronous FIFO holding packed ALU ops.
//   Ports: clk, rst (async, active-high); push_i/din_i write at tail;
//          pop_i advances head; dout_o is the head (combinational);
//          full_o, empty_o, level_o derived from the occupancy counter.
//   Pointers are $clog2(DEPTH) bits and wrap naturally (DEPTH is a power of 2).
module alu32_op_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/alu32_op_sequencer.sv
// alu32_op_sequencer
//   Issue stage for alu32: buffers tagged ops in a FIFO, drives alu32 from
//   registers and returns each result with its tag.
//   Ports: clk, rst (async, active-high);
//          bus      : op channel in_* and result channel res_* (slave side)
//          alu_a_o, alu_b_o, alu_sel_o : registered operands/opcode to alu32
//          alu_out_i: alu32 result
//          level_o  : FIFO occupancy
module alu32_op_sequencer
  import alu32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  alu32_op_sequencer_if.slave    bus,
  output logic [31:0]            alu_a_o,
  output logic [31:0]            alu_b_o,
  output logic [3:0]             alu_sel_o,
  input  logic [31:0]            alu_out_i,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int W = op_width(TAG_W);

  logic [W-1:0]     fifo_din;
  logic [W-1:0]     head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [3:0]       head_sel;
  logic [TAG_W-1:0] head_tag;

  seq_state_t       state_q;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [3:0]       alu_sel_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic             res_valid_q;

  assign fifo_din     = {bus.in_a, bus.in_b, bus.in_sel, bus.in_tag};
  assign bus.in_ready = ~fifo_full;
  assign push         = bus.in_valid & ~fifo_full;

  assign head_a   = head[W-1 -: 32];
  assign head_b   = head[W-33 -: 32];
  assign head_sel = head[TAG_W+3 : TAG_W];
  assign head_tag = head[TAG_W-1:0];

  // Pop whenever the ALU slot is free: idle, or the current result is taken.
  assign pop = ~fifo_empty &
               ((state_q == IDLE) | ((state_q == DONE) & bus.res_ready));

  alu32_op_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      // Head is loaded on every pop regardless of state.
      if (pop) begin
        alu_a_q   <= head_a;
        alu_b_q   <= head_b;
        alu_sel_q <= head_sel;
        tag_q     <= head_tag;
        err_q     <= ~sel_legal(head_sel);
      end
      case (state_q)
        IDLE: begin
          res_valid_q <= 1'b0;
          if (pop) state_q <= LOAD;
        end
        LOAD: begin
          // alu32 captures alu_* at this edge; its out is valid afterwards.
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= pop ? LOAD : IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a_o   = alu_a_q;
  assign alu_b_o   = alu_b_q;
  assign alu_sel_o = alu_sel_q;

  // alu_* are held in DONE, so alu32 keeps recomputing the same value.
  // An illegal opcode leaves alu32's out stale, hence the forced zero.
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = (res_valid_q && !err_q) ? alu_out_i : 32'd0;
  assign bus.res_tag   = tag_q;
  assign bus.res_err   = res_valid_q & err_q;

endmodule
